// File: rtl/csr_access_unit.sv
// CSR access unit: sequences csrrd/csrwr/csrxchg against a combinational CSR file
// through a four-state read / modify / write / respond FSM.
module csr_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_mask,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [13:0] csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic        csr_wr_en,
   output logic [13:0] csr_waddr,
   output logic [31:0] csr_wdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  op_q;
   logic [13:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] mask_q;
   logic [31:0] old_q;
   logic        err_q;
   logic        accept;
   logic        is_write;
   logic        is_rsvd;

   assign accept   = (state == IDLE) && req_valid && !flush;
   assign is_write = (op_q == 2'b01) || (op_q == 2'b10);
   assign is_rsvd  = (op_q == 2'b11);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = READ;
         READ: begin
            if (flush)         state_nxt = IDLE;
            else if (is_write) state_nxt = WRITE;
            else               state_nxt = RESP;
         end
         // A write already on the bus is committed even if flush arrives.
         WRITE: state_nxt = RESP;
         RESP:  if (flush || resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 2'b00;
         addr_q  <= 14'd0;
         wdata_q <= 32'd0;
         mask_q  <= 32'd0;
         old_q   <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            mask_q  <= req_mask;
         end
         if (state == READ && !flush) begin
            old_q <= is_rsvd ? 32'd0 : csr_rdata;
            err_q <= is_rsvd;
         end
      end
   end

   // Reset gates every strobe so a reset landing on WRITE never commits.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      csr_raddr  = 14'd0;
      csr_wr_en  = 1'b0;
      csr_waddr  = 14'd0;
      csr_wdata  = 32'd0;
      if (!reset) begin
         case (state)
            READ: csr_raddr = addr_q;
            WRITE: begin
               csr_wr_en = !is_rsvd;
               csr_waddr = addr_q;
               if (op_q == 2'b01) csr_wdata = wdata_q;
               else csr_wdata = (wdata_q & mask_q) | (old_q & ~mask_q);
            end
            RESP: begin
               resp_valid = 1'b1;
               resp_rdata = old_q;
               resp_err   = err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of a 64-entry CSR file.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [13:0] req_addr = 14'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] req_mask = 32'd0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [13:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_wr_en;
   logic [13:0] csr_waddr;
   logic [31:0] csr_wdata;

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_addr = 6'd0;
   logic [31:0] pl_data = 32'd0;
   logic [31:0] ref_mem [0:63];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign csr_rdata = mem[csr_raddr[5:0]];

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (csr_wr_en) mem[csr_waddr[5:0]] <= csr_wdata;
   end

   csr_access_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_mask(req_mask),
      .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_wr_en(csr_wr_en), .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata)
   );

   // Entered just after a rising edge; returns just after the handshake edge.
   task automatic do_txn(
      input  logic [1:0]  op,
      input  logic [13:0] addr,
      input  logic [31:0] wd,
      input  logic [31:0] mk,
      input  int          stall,
      output int          lat,
      output int          wcyc,
      output logic [31:0] rd,
      output logic        er,
      output int          nwr,
      output logic [13:0] wa,
      output logic [31:0] wdv,
      output bit          stable,
      output bit          early_rdy,
      output bit          rdy0
   );
      int c;
      int seen;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_mask  = mk;
      @(negedge clk);
      rdy0 = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom_range(0, 3));
      req_wdata = $urandom;
      req_mask  = $urandom;
      lat = -1; wcyc = -1; nwr = 0; seen = 0;
      rd = 32'd0; er = 1'b0; wa = 14'd0; wdv = 32'd0;
      stable = 1'b1; early_rdy = 1'b0;
      c = 1;
      while (c < 60) begin
         @(negedge clk);
         if (csr_wr_en) begin
            nwr++; wcyc = c; wa = csr_waddr; wdv = csr_wdata;
         end
         if (req_ready) early_rdy = 1'b1;
         if (resp_valid) begin
            if (seen == 0) begin
               lat = c; rd = resp_rdata; er = resp_err;
            end else if (resp_rdata !== rd || resp_err !== er) begin
               stable = 1'b0;
            end
            seen++;
            if (seen > stall) begin
               resp_ready = 1'b1;
               break;
            end
         end else if (seen > 0) begin
            stable = 1'b0;
         end
         c++;
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 64; i++) begin
         pl_en   = 1'b1;
         pl_addr = 6'(i);
         if (i == 'h30)    pl_data = 32'hDEADBEEF;
         else if (i == 0)  pl_data = 32'h000000F0;
         else              pl_data = $urandom;
         ref_mem[i] = pl_data;
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || csr_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctl got rdy=%b vld=%b wr=%b want 1 0 0",
                  req_ready, resp_valid, csr_wr_en);
      end
      vectors++;
      if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_resp got %h/%b want 0/0", resp_rdata, resp_err);
      end
      vectors++;
      if (csr_raddr !== 14'd0 || csr_waddr !== 14'd0 || csr_wdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_bus got %h %h %h want 0 0 0",
                  csr_raddr, csr_waddr, csr_wdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_csrrd;
      int lat, wcyc, nwr;
      logic [31:0] rd, wdv;
      logic er;
      logic [13:0] wa;
      bit st, er_rdy, r0;
      do_txn(2'b00, 14'h30, 32'h12345678, 32'hFFFFFFFF, 0,
             lat, wcyc, rd, er, nwr, wa, wdv, st, er_rdy, r0);
      vectors++;
      if (lat !== 2) begin
         miscompares++; $display("FAIL rd_latency got %0d want 2", lat);
      end
      vectors++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         miscompares++; $display("FAIL rd_data got %h/%b want deadbeef/0", rd, er);
      end
      vectors++;
      if (nwr !== 0) begin
         miscompares++; $display("FAIL rd_nowrite got %0d writes want 0", nwr);
      end
   endtask

   task automatic test_csrxchg;
      int lat, wcyc, nwr;
      logic [31:0] rd, wdv;
      logic er;
      logic [13:0] wa;
      bit st, er_rdy, r0;
      do_txn(2'b10, 14'h0, 32'h0000000F, 32'h000000FF, 0,
             lat, wcyc, rd, er, nwr, wa, wdv, st, er_rdy, r0);
      ref_mem[0] = 32'h0000000F;
      vectors++;
      if (nwr !== 1 || wcyc !== 2) begin
         miscompares++;
         $display("FAIL xchg_write got %0d writes at +%0d want 1 at +2", nwr, wcyc);
      end
      vectors++;
      if (wa !== 14'h0 || wdv !== 32'h0000000F) begin
         miscompares++; $display("FAIL xchg_wdata got %h@%h want f@0", wdv, wa);
      end
      vectors++;
      if (lat !== 3 || rd !== 32'h000000F0) begin
         miscompares++;
         $display("FAIL xchg_resp got +%0d %h want +3 000000f0", lat, rd);
      end
   endtask

   task automatic test_stall;
      int lat, wcyc, nwr;
      logic [31:0] rd, wdv;
      logic er;
      logic [13:0] wa;
      bit st, er_rdy, r0;
      logic [31:0] old;
      old = ref_mem[6];
      do_txn(2'b01, 14'h6, 32'h1C000000, 32'h0, 5,
             lat, wcyc, rd, er, nwr, wa, wdv, st, er_rdy, r0);
      ref_mem[6] = 32'h1C000000;
      vectors++;
      if (st !== 1'b1 || lat !== 3 || rd !== old) begin
         miscompares++;
         $display("FAIL stall_hold got st=%b +%0d %h want 1 +3 %h", st, lat, rd, old);
      end
      vectors++;
      if (er_rdy !== 1'b0) begin
         miscompares++; $display("FAIL stall_ready got early ready=1 want 0");
      end
      vectors++;
      if (nwr !== 1 || wdv !== 32'h1C000000 || wa !== 14'h6) begin
         miscompares++;
         $display("FAIL stall_write got %0d x %h@%h want 1 x 1c000000@6", nwr, wdv, wa);
      end
   endtask

   task automatic test_reserved;
      int lat, wcyc, nwr;
      logic [31:0] rd, wdv;
      logic er;
      logic [13:0] wa;
      bit st, er_rdy, r0;
      do_txn(2'b11, 14'h5, $urandom, $urandom, 1,
             lat, wcyc, rd, er, nwr, wa, wdv, st, er_rdy, r0);
      vectors++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
         miscompares++;
         $display("FAIL rsvd_resp got +%0d err=%b %h want +2 1 0", lat, er, rd);
      end
      vectors++;
      if (nwr !== 0) begin
         miscompares++; $display("FAIL rsvd_nowrite got %0d writes want 0", nwr);
      end
   endtask

   task automatic test_flush_idle;
      int bad;
      req_valid = 1'b1; req_op = 2'b00; req_addr = 14'h3; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (req_ready !== 1'b1 || resp_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++; $display("FAIL flush_idle got %0d busy cycles want 0", bad);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_read;
      int wr, vl;
      req_valid = 1'b1; req_op = 2'b01; req_addr = 14'h9; req_wdata = $urandom;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL flush_read_ready got %b want 1", req_ready);
      end
      wr = 0; vl = 0;
      for (int i = 0; i < 4; i++) begin
         if (csr_wr_en) wr++;
         if (resp_valid) vl++;
         @(negedge clk);
      end
      vectors++;
      if (wr !== 0 || vl !== 0) begin
         miscompares++;
         $display("FAIL flush_read got %0d writes %0d resps want 0 0", wr, vl);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_write;
      logic [31:0] old, wd;
      int n;
      old = ref_mem[12]; wd = $urandom;
      req_valid = 1'b1; req_op = 2'b01; req_addr = 14'd12; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      vectors++;
      if (csr_wr_en !== 1'b1 || csr_wdata !== wd) begin
         miscompares++;
         $display("FAIL flush_write_commit got %b %h want 1 %h", csr_wr_en, csr_wdata, wd);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      ref_mem[12] = wd;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 10) begin
         @(negedge clk); n++;
      end
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== old) begin
         miscompares++;
         $display("FAIL flush_write_resp got %b %h want 1 %h", resp_valid, resp_rdata, old);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_flush_resp;
      req_valid = 1'b1; req_op = 2'b00; req_addr = 14'd20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_resp got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_write;
      req_valid = 1'b1; req_op = 2'b10; req_addr = 14'd33;
      req_wdata = $urandom; req_mask = 32'hFFFFFFFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (csr_wr_en !== 1'b0) begin
         miscompares++; $display("FAIL rst_write_strobe got %b want 0", csr_wr_en);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || csr_wr_en !== 1'b0 ||
          resp_rdata !== 32'd0 || resp_err !== 1'b0 || csr_raddr !== 14'd0 ||
          csr_waddr !== 14'd0 || csr_wdata !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_write_outs got rdy=%b vld=%b wr=%b rd=%h want reset values",
                  req_ready, resp_valid, csr_wr_en, resp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [13:0] addr;
      logic [31:0] wd, mk, old, exp_rd, exp_wd;
      bit          exp_w;
      int lat, wcyc, nwr, stall;
      logic [31:0] rd, wdv;
      logic er;
      logic [13:0] wa;
      bit st, er_rdy, r0;
      for (int n = 0; n < 60; n++) begin
         op    = 2'($urandom_range(0, 3));
         addr  = 14'($urandom_range(0, 63));
         wd    = $urandom;
         mk    = $urandom;
         stall = $urandom_range(0, 3);
         old    = ref_mem[addr[5:0]];
         exp_w  = (op == 2'b01) || (op == 2'b10);
         exp_rd = (op == 2'b11) ? 32'd0 : old;
         exp_wd = (op == 2'b01) ? wd : (wd & mk) | (old & ~mk);
         do_txn(op, addr, wd, mk, stall,
                lat, wcyc, rd, er, nwr, wa, wdv, st, er_rdy, r0);
         if (exp_w) ref_mem[addr[5:0]] = exp_wd;
         vectors++;
         if (r0 !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready txn %0d got 0 want 1", n);
         end
         vectors++;
         if (lat !== (exp_w ? 3 : 2)) begin
            miscompares++;
            $display("FAIL rand_lat txn %0d op %0d got %0d want %0d",
                     n, op, lat, exp_w ? 3 : 2);
         end
         vectors++;
         if (rd !== exp_rd || er !== (op == 2'b11)) begin
            miscompares++;
            $display("FAIL rand_resp txn %0d got %h/%b want %h/%b",
                     n, rd, er, exp_rd, op == 2'b11);
         end
         vectors++;
         if (nwr !== (exp_w ? 1 : 0)) begin
            miscompares++;
            $display("FAIL rand_nwr txn %0d got %0d want %0d", n, nwr, exp_w ? 1 : 0);
         end
         if (exp_w) begin
            vectors++;
            if (wdv !== exp_wd || wa !== addr || wcyc !== 2) begin
               miscompares++;
               $display("FAIL rand_write txn %0d got %h@%h +%0d want %h@%h +2",
                        n, wdv, wa, wcyc, exp_wd, addr);
            end
         end
         vectors++;
         if (st !== 1'b1 || er_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_hold txn %0d got stable=%b early_rdy=%b want 1 0",
                     n, st, er_rdy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_csrrd();
      test_csrxchg();
      test_stall();
      test_reserved();
      test_flush_idle();
      test_flush_read();
      test_flush_write();
      test_flush_resp();
      test_reset_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
